bb_ram_loader: RTL and testbench
================================

Name: bb_ram_loader

Overview:
Byte-stream packet writer that sits directly upstream of the 8 KB bb_ram packet buffer. It accepts received Ethernet bytes over a valid/ready stream with sop/eop framing and packs them little-endian into 32-bit words. It writes those words into the buffer using per-byte write enables. After end of packet it reports the packet length and error status, then holds the buffer until the consuming core releases it.

Parameters:
BUF_BYTES, 8192, buffer capacity in bytes; must be a multiple of 4; sets address width 12:2 and overflow limit
AUTO_RELEASE, 0, 1 = return to IDLE one cycle after pkt_done without waiting for buf_release

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data/rx_sop/rx_eop valid this cycle
rx_sop  in  1  first byte of packet
rx_eop  in  1  last byte of packet
rx_ready  out  1  loader accepts byte when rx_valid && rx_ready
ram_addr  out  11  word address [12:2] to buffer
ram_data  out  32  write data; byte n of a word on bits 8n+7:8n
ram_we  out  4  per-byte write enables
ram_en  out  1  buffer enable; high only on write cycles
pkt_done  out  1  one-cycle pulse: packet fully written
pkt_len  out  14  byte count of last packet (0..8192); valid from pkt_done until next sop accepted
pkt_err  out  1  last packet overflowed; valid with pkt_len
buf_release  in  1  consumer finished with buffer; re-arms loader

Behaviour:
- Reset (async, immediate): state IDLE; rx_ready=1, ram_en=0, ram_we=0, ram_addr=0, ram_data=0, pkt_done=0, pkt_len=0, pkt_err=0; byte counter and pack register cleared.
- Accepted byte = rx_valid && rx_ready.
- States: IDLE, RECV, DONE (plus HDR under the optional feature).
- IDLE: rx_ready=1. Non-sop bytes are discarded. An accepted sop byte is stored as byte 0 and moves the block to RECV.
- RECV: rx_ready=1. Byte k (0-based) goes to lane k%4 of word k/4.
- Word write: registered, issued the cycle after the byte filling lane 3 is accepted. ram_en=1, ram_we=4'hF, ram_addr=k/4.
- eop with partial word: write issued the cycle after eop. ram_we has only the filled lanes set (e.g. 1 byte -> 4'b0001, 3 bytes -> 4'b0111). Unfilled lanes of ram_data are 0.
- End of packet: pkt_done pulses in the same cycle as the final write, then state goes to DONE. pkt_len = bytes received, saturated at BUF_BYTES.
- sop and eop on the same byte: a 1-byte packet; one write with we=4'b0001; pkt_len=1.
- Overflow: bytes beyond BUF_BYTES are still accepted (drained) but not written. pkt_err=1 at done. The address never wraps.
- sop accepted in RECV: the current packet is aborted with no pkt_done. The new packet restarts at byte 0 / address 0, and any pending partial word is dropped.
- DONE: rx_ready=0. buf_release (level, sampled each cycle) moves the block to IDLE next cycle. With AUTO_RELEASE=1, DONE lasts exactly one cycle.
- buf_release outside DONE: ignored.
- Throughput: 1 byte/cycle sustained; no back-pressure in RECV.

Optional Feature:
Macro BB_LOADER_LEN_HDR_EN.
- Defined:
  - Payload starts at byte offset 4 (word 1). Capacity for the overflow check is BUF_BYTES-4.
  - After the final data write, state HDR issues one extra write: ram_addr=0, ram_we=4'hF, ram_data={pkt_err, 17'b0, pkt_len}.
  - pkt_done pulses with this header write, one cycle later than without the macro.
- Undefined: no header; payload starts at word 0; no HDR state.

Test Plan:
- sop byte 0x11, bytes 0x22, 0x33, then eop byte 0x44 -> one write: addr 0, data 0x44332211, we 4'hF; pkt_done in the same cycle; pkt_len=4; pkt_err=0.
- 6-byte packet 0x01..0x06 -> writes: addr 0 data 0x04030201 we F; then addr 1 data 0x00000605 we 4'b0011; pkt_len=6.
- 8200-byte packet -> 2048 full-word writes to addrs 0..2047 and none after; rx_ready stays 1 through eop; pkt_len=8192; pkt_err=1.
- 3 bytes, then a new sop -> no pkt_done; the 2-byte second packet writes addr 0 we 4'b0011; pkt_len=2; bytes before the first sop are dropped.
- After done, hold buf_release=0 for 10 cycles -> rx_ready=0 throughout; assert buf_release -> rx_ready=1 next cycle. Assert reset mid-RECV -> all outputs return to reset values immediately.
- With BB_LOADER_LEN_HDR_EN, 5-byte packet -> writes: addr 1 full word; addr 2 we 4'b0001; then addr 0 data 0x00000005 with pkt_done.

Source files
------------

// File: rtl/bb_ram_loader.sv
// Packs an sop/eop byte stream little-endian into 32-bit bb_ram writes, then reports packet length and overflow.
// Latency: a word is written the cycle after its lane-3 byte (or eop) is accepted; pkt_done rides the final write.
// Backpressure: none while idle/receiving (1 byte/cycle); rx_ready is low from end of packet until release.
// Optional macro BB_LOADER_LEN_HDR_EN: payload starts at word 1 and an {err, len} header is written to word 0 afterwards.
module bb_ram_loader #(
    parameter int BUF_BYTES    = 8192,
    parameter int AUTO_RELEASE = 0,
    localparam int AW = $clog2(BUF_BYTES) - 2,
    localparam int LW = $clog2(BUF_BYTES) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_rx_sop,
    input  logic          i_rx_eop,
    output logic          o_rx_ready,
    output logic [AW-1:0] o_ram_addr,
    output logic [31:0]   o_ram_data,
    output logic [3:0]    o_ram_we,
    output logic          o_ram_en,
    output logic          o_pkt_done,
    output logic [LW-1:0] o_pkt_len,
    output logic          o_pkt_err,
    input  logic          i_buf_release
);

`ifdef BB_LOADER_LEN_HDR_EN
    localparam int HDR_BYTES = 4;
`else
    localparam int HDR_BYTES = 0;
`endif

    // Payload capacity; bytes past this are drained but never written, so the address cannot wrap.
    localparam logic [LW-1:0] CAP       = LW'(BUF_BYTES - HDR_BYTES);
    localparam logic [AW-1:0] BASE_WORD = AW'(HDR_BYTES / 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
`ifdef BB_LOADER_LEN_HDR_EN
        ST_HDR,
`endif
        ST_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [LW-1:0] r_cnt, w_cnt_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic [31:0]   r_pack, w_pack_nxt;
    logic          r_ram_en, w_ram_en;
    logic [3:0]    r_ram_we, w_ram_we;
    logic [AW-1:0] r_ram_addr, w_ram_addr;
    logic [31:0]   r_ram_data, w_ram_data;
    logic          r_pkt_done, w_pkt_done;
    logic [LW-1:0] r_pkt_len, w_pkt_len;
    logic          r_pkt_err, w_pkt_err;

    logic          w_rx_ready;
    logic          w_accept;
    logic [LW-1:0] w_cnt_base;
    logic [31:0]   w_pack_base;
    logic          w_ovf_base;
    logic [1:0]    w_lane;

    assign w_rx_ready = (r_state == ST_IDLE) || (r_state == ST_RECV);
    assign w_accept   = i_rx_valid && w_rx_ready;

    // Next-state, byte packing and write/done generation for the registered buffer interface.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_pack_nxt  = r_pack;
        w_ram_en    = 1'b0;
        w_ram_we    = 4'h0;
        w_ram_addr  = r_ram_addr;
        w_ram_data  = r_ram_data;
        w_pkt_done  = 1'b0;
        w_pkt_len   = r_pkt_len;
        w_pkt_err   = r_pkt_err;
        // An sop always restarts at byte 0, which also drops any partial word of an aborted packet.
        w_cnt_base  = i_rx_sop ? '0 : r_cnt;
        w_pack_base = i_rx_sop ? 32'h0 : r_pack;
        w_ovf_base  = i_rx_sop ? 1'b0 : r_ovf;
        w_lane      = w_cnt_base[1:0];

        case (r_state)
            ST_IDLE, ST_RECV: begin
                // In IDLE only an sop byte starts a packet; stray bytes are swallowed.
                if (w_accept && (i_rx_sop || (r_state == ST_RECV))) begin
                    w_state_nxt = ST_RECV;
                    if (w_cnt_base < CAP) begin
                        w_pack_base[8*w_lane +: 8] = i_rx_data;
                        w_cnt_nxt = w_cnt_base + LW'(1);
                        if ((w_lane == 2'd3) || i_rx_eop) begin
                            w_ram_en   = 1'b1;
                            w_ram_addr = BASE_WORD + AW'(w_cnt_base >> 2);
                            w_ram_data = w_pack_base;
                            case (w_lane)
                                2'd0:    w_ram_we = 4'b0001;
                                2'd1:    w_ram_we = 4'b0011;
                                2'd2:    w_ram_we = 4'b0111;
                                default: w_ram_we = 4'b1111;
                            endcase
                            w_pack_base = 32'h0;
                        end
                    end else begin
                        w_cnt_nxt  = w_cnt_base;
                        w_ovf_base = 1'b1;
                    end
                    w_pack_nxt = w_pack_base;
                    w_ovf_nxt  = w_ovf_base;
                    if (i_rx_eop) begin
                        w_pkt_len = w_cnt_nxt;
                        w_pkt_err = w_ovf_base;
`ifdef BB_LOADER_LEN_HDR_EN
                        w_state_nxt = ST_HDR;
`else
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef BB_LOADER_LEN_HDR_EN
            ST_HDR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 4'hF;
                w_ram_addr  = '0;
                w_ram_data  = {r_pkt_err, {(31-LW){1'b0}}, r_pkt_len};
                w_pkt_done  = 1'b1;
                w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                if ((AUTO_RELEASE != 0) || i_buf_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte counter, pack register and registered buffer/status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_pack     <= 32'h0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 4'h0;
            r_ram_addr <= '0;
            r_ram_data <= 32'h0;
            r_pkt_done <= 1'b0;
            r_pkt_len  <= '0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_pack     <= w_pack_nxt;
            r_ram_en   <= w_ram_en;
            r_ram_we   <= w_ram_we;
            r_ram_addr <= w_ram_addr;
            r_ram_data <= w_ram_data;
            r_pkt_done <= w_pkt_done;
            r_pkt_len  <= w_pkt_len;
            r_pkt_err  <= w_pkt_err;
        end
    end

    assign o_rx_ready = w_rx_ready;
    assign o_ram_en   = r_ram_en;
    assign o_ram_we   = r_ram_we;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_data = r_ram_data;
    assign o_pkt_done = r_pkt_done;
    assign o_pkt_len  = r_pkt_len;
    assign o_pkt_err  = r_pkt_err;

endmodule

// File: tb/tb_bb_ram_loader.sv
// Bench for bb_ram_loader (default build): directed packets, scoreboard of expected buffer writes / done events.
// Stimulus pushes expected events; an independent negedge monitor pops and compares.
// Direct checks cover reset values, rx_ready in DONE, release and asynchronous reset mid-packet.
module tb_bb_ram_loader;

    typedef struct packed {
        logic        en;
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic        done;
        logic [13:0] len;
        logic        err;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, buf_release;
    logic        rx_ready, ram_en, pkt_done, pkt_err;
    logic [10:0] ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_we;
    logic [13:0] pkt_len;

    ev_t q[$];
    int  total = 0, bad = 0;
    int  mon_total = 0, mon_bad = 0;

    bb_ram_loader dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .i_rx_sop      (rx_sop),
        .i_rx_eop      (rx_eop),
        .o_rx_ready    (rx_ready),
        .o_ram_addr    (ram_addr),
        .o_ram_data    (ram_data),
        .o_ram_we      (ram_we),
        .o_ram_en      (ram_en),
        .o_pkt_done    (pkt_done),
        .o_pkt_len     (pkt_len),
        .o_pkt_err     (pkt_err),
        .i_buf_release (buf_release)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic en, input logic [10:0] a, input logic [31:0] d,
                                 input logic [3:0] we, input logic done, input logic [13:0] len,
                                 input logic err);
        ev_t e;
        e.en   = en;
        e.addr = en ? a : 11'h0;
        e.data = en ? d : 32'h0;
        e.we   = en ? we : 4'h0;
        e.done = done;
        e.len  = done ? len : 14'h0;
        e.err  = done ? err : 1'b0;
        q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e, input logic r);
        rx_data = d; rx_valid = v; rx_sop = s; rx_eop = e; buf_release = r;
        @(posedge clk);
        #1;
    endtask

    task automatic release_buf();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        buf_release = 1'b0;
    endtask

    // Scoreboard monitor: every write or done pulse must match the next expected event.
    always @(negedge clk) begin
        ev_t act;
        ev_t req;
        if (!rst && (ram_en || pkt_done)) begin
            act.en   = ram_en;
            act.addr = ram_en ? ram_addr : 11'h0;
            act.data = ram_en ? ram_data : 32'h0;
            act.we   = ram_en ? ram_we : 4'h0;
            act.done = pkt_done;
            act.len  = pkt_done ? pkt_len : 14'h0;
            act.err  = pkt_done ? pkt_err : 1'b0;
            mon_total++;
            if (q.size() == 0) begin
                mon_bad++;
                $display("FAIL unexpected_event: got en=%0d addr=%0h data=%08h we=%0h done=%0d len=%0d err=%0d, required none",
                         act.en, act.addr, act.data, act.we, act.done, act.len, act.err);
            end else begin
                req = q.pop_front();
                if (act !== req) begin
                    mon_bad++;
                    $display("FAIL write_event: got en=%0d addr=%0h data=%08h we=%0h done=%0d len=%0d err=%0d, required en=%0d addr=%0h data=%08h we=%0h done=%0d len=%0d err=%0d",
                             act.en, act.addr, act.data, act.we, act.done, act.len, act.err,
                             req.en, req.addr, req.data, req.we, req.done, req.len, req.err);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int nr;
        rst = 1'b1;
        rx_data = 8'h0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; buf_release = 1'b0;
        #2;
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_ram_en",   32'(ram_en),   32'h0);
        chk("rst_ram_we",   32'(ram_we),   32'h0);
        chk("rst_pkt_done", 32'(pkt_done), 32'h0);
        chk("rst_pkt_len",  32'(pkt_len),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4-byte packet: one full word, done on the same cycle.
        push(1'b1, 11'd0, 32'h44332211, 4'hF, 1'b1, 14'd4, 1'b0);
        drive(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        rx_valid = 1'b0;
        // Buffer held: rx_ready stays low, sop bytes offered here are ignored.
        for (int i = 0; i < 10; i++) begin
            chk("done_rx_ready_low", 32'(rx_ready), 32'h0);
            drive(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("done_pkt_len_held", 32'(pkt_len), 32'd4);
        release_buf();
        chk("release_rx_ready", 32'(rx_ready), 32'h1);

        // Release while idle must be harmless; then sop+eop on one byte.
        push(1'b1, 11'd0, 32'h0000005A, 4'b0001, 1'b1, 14'd1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        release_buf();

        // 6-byte packet: full word then 2-lane partial word.
        push(1'b1, 11'd0, 32'h04030201, 4'hF, 1'b0, 14'd0, 1'b0);
        push(1'b1, 11'd1, 32'h00000605, 4'b0011, 1'b1, 14'd6, 1'b0);
        for (int k = 1; k <= 6; k++) drive(8'(k), 1'b1, k == 1, k == 6, 1'b0);
        release_buf();

        // 7-byte packet: partial word with three lanes.
        push(1'b1, 11'd0, 32'hC4C3C2C1, 4'hF, 1'b0, 14'd0, 1'b0);
        push(1'b1, 11'd1, 32'h00C7C6C5, 4'b0111, 1'b1, 14'd7, 1'b0);
        for (int k = 1; k <= 7; k++) drive(8'(8'hC0 + k), 1'b1, k == 1, k == 7, 1'b0);
        release_buf();

        // Stray bytes in IDLE dropped; 3-byte packet aborted by a new sop.
        push(1'b1, 11'd0, 32'h00000B0A, 4'b0011, 1'b1, 14'd2, 1'b0);
        drive(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h0B, 1'b1, 1'b0, 1'b1, 1'b0);
        release_buf();

        // 8200-byte packet: 2048 full words, overflow drained, done without a write.
        for (int w = 0; w < 2048; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            push(1'b1, 11'(w), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 4'hF, 1'b0, 14'd0, 1'b0);
        end
        push(1'b0, 11'd0, 32'h0, 4'h0, 1'b1, 14'd8192, 1'b1);
        nr = 0;
        for (int k = 0; k < 8200; k++) begin
            if (rx_ready !== 1'b1) nr++;
            drive(8'(k), 1'b1, k == 0, k == 8199, 1'b0);
        end
        chk("ovf_rx_ready_not_low_cycles", 32'(nr), 32'd0);
        chk("ovf_pkt_len", 32'(pkt_len), 32'd8192);
        chk("ovf_pkt_err", 32'(pkt_err), 32'h1);
        release_buf();

        // Asynchronous reset in the middle of a packet.
        drive(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h98, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_rx_ready", 32'(rx_ready), 32'h1);
        chk("arst_ram_en",   32'(ram_en),   32'h0);
        chk("arst_ram_we",   32'(ram_we),   32'h0);
        chk("arst_ram_addr", 32'(ram_addr), 32'h0);
        chk("arst_ram_data", ram_data,      32'h0);
        chk("arst_pkt_done", 32'(pkt_done), 32'h0);
        chk("arst_pkt_len",  32'(pkt_len),  32'h0);
        chk("arst_pkt_err",  32'(pkt_err),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh packet after reset: no leftover bytes from the interrupted one.
        push(1'b1, 11'd0, 32'hA4A3A2A1, 4'hF, 1'b1, 14'd4, 1'b0);
        for (int k = 1; k <= 4; k++) drive(8'(8'hA0 + k), 1'b1, k == 1, k == 4, 1'b0);
        release_buf();
        for (int i = 0; i < 5; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        total += mon_total;
        bad   += mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
